mem_wb_stage: RTL

Parametrised MEM/WB pipeline stage for the RV32I core and its RV64 variant. It replaces the fixed MEM/WB register and write-data mux. Beyond registering fields and selecting write data, it adds:
- valid/ready flow control with flush
- a wait state for late load data
- byte/half/word load extraction with sign/zero extension and misalignment detection
- a forwarding port and retire/stall counters

It sits between the data-memory stage and the register-file write port.

---
 rtl/mem_wb_stage_if.sv | 72 +++++++
 rtl/mem_wb_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage_if.sv
// ---------------------------------------------------------------------------
// mem_wb_stage_if
// Bundle between the data-memory stage, the MEM/WB stage and the register
// file write port.
//
// Signals (direction as seen by the MEM/WB stage, i.e. the slave modport):
//   flush            in   kill the entry being accepted and any waiting load
//   in_valid         in   MEM stage presents an instruction
//   in_ready         out  stage can accept
//   in_rd/in_we      in   destination register / writes rd
//   in_wb_sel        in   write-back source select
//   in_funct3        in   load type
//   in_addr_lo       in   load byte offset
//   in_alu_result, in_pc_plus_4, in_immu, in_pc_plus_immu  in  candidates
//   mem_rdata        in   raw aligned memory word
//   mem_rvalid       in   mem_rdata valid this cycle
//   rf_we/rf_waddr/rf_wdata          out  register-file write port
//   fwd_valid/fwd_rd/fwd_data        out  bypass copy of the write port
//   load_misaligned/illegal_sel      out  one-cycle fault pulses
//   retire_count/stall_count         out  performance counters
// ---------------------------------------------------------------------------
interface mem_wb_stage_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    localparam int OFS_W = $clog2(XLEN / 8);

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [REG_AW-1:0] in_rd;
    logic              in_we;
    logic [2:0]        in_wb_sel;
    logic [2:0]        in_funct3;
    logic [OFS_W-1:0]  in_addr_lo;
    logic [XLEN-1:0]   in_alu_result;
    logic [XLEN-1:0]   in_pc_plus_4;
    logic [XLEN-1:0]   in_immu;
    logic [XLEN-1:0]   in_pc_plus_immu;
    logic [XLEN-1:0]   mem_rdata;
    logic              mem_rvalid;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [XLEN-1:0]   rf_wdata;
    logic              fwd_valid;
    logic [REG_AW-1:0] fwd_rd;
    logic [XLEN-1:0]   fwd_data;
    logic              load_misaligned;
    logic              illegal_sel;
    logic [CNT_W-1:0]  retire_count;
    logic [CNT_W-1:0]  stall_count;

    // Upstream side: drives the instruction and memory response, observes
    // the write port and status.
    modport master (
        output flush, in_valid, in_rd, in_we, in_wb_sel, in_funct3, in_addr_lo,
               in_alu_result, in_pc_plus_4, in_immu, in_pc_plus_immu,
               mem_rdata, mem_rvalid,
        input  in_ready, rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_rd, fwd_data,
               load_misaligned, illegal_sel, retire_count, stall_count
    );

    // The MEM/WB stage itself.
    modport slave (
        input  flush, in_valid, in_rd, in_we, in_wb_sel, in_funct3, in_addr_lo,
               in_alu_result, in_pc_plus_4, in_immu, in_pc_plus_immu,
               mem_rdata, mem_rvalid,
        output in_ready, rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_rd, fwd_data,
               load_misaligned, illegal_sel, retire_count, stall_count
    );
endinterface

// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
// MEM/WB pipeline stage: captures an instruction from the memory stage,
// waits for late load data when needed, extracts/extends load data, selects
// write-back data and drives the register-file write port plus a bypass copy.
// Also counts committed entries and cycles spent waiting for load data.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    mem_wb_stage_if.slave (instruction in, memory data in,
//          register-file write / forwarding / fault pulses / counters out)
// ---------------------------------------------------------------------------
module mem_wb_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input logic           clk,
    input logic           rst_n,
    mem_wb_stage_if.slave bus
);
    localparam int OFS_W = $clog2(XLEN / 8);

    localparam logic [2:0] SEL_ALU   = 3'b000;
    localparam logic [2:0] SEL_MEM   = 3'b001;
    localparam logic [2:0] SEL_PC4   = 3'b010;
    localparam logic [2:0] SEL_IMMU  = 3'b011;
    localparam logic [2:0] SEL_PCIMM = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_VALID = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    // Keep the low nbits of v, sign- or zero-extended to XLEN.
    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v,
                                               input int nbits,
                                               input logic sgn);
        logic signed [XLEN-1:0] t;
        logic        [XLEN-1:0] u;
        t = $signed(v << (XLEN - nbits));
        u = v << (XLEN - nbits);
        if (sgn) begin
            t = t >>> (XLEN - nbits);
            return t;
        end
        u = u >> (XLEN - nbits);
        return u;
    endfunction

    // Returns {misaligned, extracted value}. Unknown or width-illegal
    // funct3 codes are flagged as misaligned so the write is suppressed.
    function automatic logic [XLEN:0] load_extract(input logic [2:0]       f3,
                                                   input logic [OFS_W-1:0] ofs,
                                                   input logic [XLEN-1:0]  raw);
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] val;
        logic            mis;
        sh  = raw >> {ofs, 3'b000};
        val = '0;
        mis = 1'b0;
        case (f3)
            3'b000: val = extend(sh, 8, 1'b1);
            3'b100: val = extend(sh, 8, 1'b0);
            3'b001: begin val = extend(sh, 16, 1'b1); mis = ofs[0];          end
            3'b101: begin val = extend(sh, 16, 1'b0); mis = ofs[0];          end
            3'b010: begin val = extend(sh, 32, 1'b1); mis = (ofs[1:0] != 0); end
            3'b110: begin
                val = extend(sh, 32, 1'b0);
                mis = (XLEN != 64) || (ofs[1:0] != 0);
            end
            3'b011: begin
                val = sh;
                mis = (XLEN != 64) || (ofs != '0);
            end
            default: mis = 1'b1;
        endcase
        return {mis, val};
    endfunction

    state_t            r_state;
    state_t            w_next;

    logic [REG_AW-1:0] r_rd_p1;
    logic              r_we_p1;
    logic [2:0]        r_sel_p1;
    logic [2:0]        r_funct3_p1;
    logic [OFS_W-1:0]  r_addr_lo_p1;
    logic [XLEN-1:0]   r_alu_p1;
    logic [XLEN-1:0]   r_pc4_p1;
    logic [XLEN-1:0]   r_immu_p1;
    logic [XLEN-1:0]   r_pcimm_p1;
    logic [XLEN-1:0]   r_rdata_p1;
    logic [CNT_W-1:0]  r_retire_cnt;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_accept;
    logic              w_is_load;
    logic              w_cap_rdata;
    logic [XLEN:0]     w_ld;
    logic              w_misal;
    logic              w_sel_legal;
    logic [XLEN-1:0]   w_sel_data;
    logic              w_commit;
    logic              w_we;

    assign w_accept  = bus.in_valid && (r_state != S_WAIT) && !bus.flush;
    assign w_is_load = (bus.in_wb_sel == SEL_MEM) && bus.in_we;
    // Load data lands either together with the accept or later in WAIT;
    // a flush in WAIT wins over arriving data.
    assign w_cap_rdata = bus.mem_rvalid &&
                         (w_accept || ((r_state == S_WAIT) && !bus.flush));

    // ---- FSM state register ----
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // ---- FSM next state ----
    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE, S_VALID: begin
                if (w_accept)
                    w_next = (w_is_load && !bus.mem_rvalid) ? S_WAIT : S_VALID;
                else
                    w_next = S_IDLE;
            end
            S_WAIT: begin
                if (bus.flush)           w_next = S_IDLE;
                else if (bus.mem_rvalid) w_next = S_VALID;
                else                     w_next = S_WAIT;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // ---- stage p1: captured instruction fields ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_p1      <= '0;
            r_we_p1      <= 1'b0;
            r_sel_p1     <= '0;
            r_funct3_p1  <= '0;
            r_addr_lo_p1 <= '0;
            r_alu_p1     <= '0;
            r_pc4_p1     <= '0;
            r_immu_p1    <= '0;
            r_pcimm_p1   <= '0;
            r_rdata_p1   <= '0;
        end else begin
            if (w_accept) begin
                r_rd_p1      <= bus.in_rd;
                r_we_p1      <= bus.in_we;
                r_sel_p1     <= bus.in_wb_sel;
                r_funct3_p1  <= bus.in_funct3;
                r_addr_lo_p1 <= bus.in_addr_lo;
                r_alu_p1     <= bus.in_alu_result;
                r_pc4_p1     <= bus.in_pc_plus_4;
                r_immu_p1    <= bus.in_immu;
                r_pcimm_p1   <= bus.in_pc_plus_immu;
            end
            if (w_cap_rdata)
                r_rdata_p1 <= bus.mem_rdata;
        end
    end

    // ---- performance counters ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_retire_cnt <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (r_state == S_VALID) r_retire_cnt <= r_retire_cnt + CNT_W'(1);
            if (r_state == S_WAIT)  r_stall_cnt  <= r_stall_cnt + CNT_W'(1);
        end
    end

    // ---- FSM outputs: commit / write-back ----
    always_comb begin
        w_ld        = load_extract(r_funct3_p1, r_addr_lo_p1, r_rdata_p1);
        w_misal     = (r_sel_p1 == SEL_MEM) && w_ld[XLEN];
        w_sel_legal = (r_sel_p1 <= SEL_PCIMM);
        case (r_sel_p1)
            SEL_ALU:   w_sel_data = r_alu_p1;
            SEL_MEM:   w_sel_data = w_ld[XLEN-1:0];
            SEL_PC4:   w_sel_data = r_pc4_p1;
            SEL_IMMU:  w_sel_data = r_immu_p1;
            SEL_PCIMM: w_sel_data = r_pcimm_p1;
            default:   w_sel_data = '0;
        endcase
        w_commit = (r_state == S_VALID);
        w_we     = w_commit && r_we_p1 && (r_rd_p1 != '0) && w_sel_legal && !w_misal;

        bus.in_ready        = (r_state != S_WAIT);
        bus.rf_we           = w_we;
        bus.rf_waddr        = w_we ? r_rd_p1 : '0;
        bus.rf_wdata        = w_we ? w_sel_data : '0;
        bus.fwd_valid       = w_we;
        bus.fwd_rd          = w_we ? r_rd_p1 : '0;
        bus.fwd_data        = w_we ? w_sel_data : '0;
        bus.load_misaligned = w_commit && r_we_p1 && w_misal;
        bus.illegal_sel     = w_commit && r_we_p1 && !w_sel_legal;
    end

    assign bus.retire_count = r_retire_cnt;
    assign bus.stall_count  = r_stall_cnt;

endmodule
